// File: rtl/cond_unit_if.sv
// Decoder-to-condition-stage bundle: raw write requests and ALU flags in,
// qualified datapath strobes and architectural flags out.
interface cond_unit_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondExDelayed;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags, CondExDelayed
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags, CondExDelayed
    );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, ARM condition evaluation and
// one-cycle-delayed qualification of the multicycle FSM write strobes.
module cond_unit #(
    parameter bit COND_1111_EXEC = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);
    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_ex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Evaluated from the registered flags only, so a flag write in the same
    // cycle cannot influence its own condition check.
    always_comb begin
        cond_ex = 1'b0;
        unique case (bus.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = COND_1111_EXEC;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (bus.FlagW[1] && cond_ex) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] && cond_ex) flags_q[1:0] <= bus.ALUFlags[1:0];
            cond_ex_q <= cond_ex;
        end
    end

    // NextPC bypasses the condition so an annulled instruction still advances.
    assign bus.PCWrite       = (bus.PCS & cond_ex_q) | bus.NextPC;
    assign bus.RegWrite      = bus.RegW & cond_ex_q;
    assign bus.MemWrite      = bus.MemW & cond_ex_q;
    assign bus.Flags         = flags_q;
    assign bus.CondExDelayed = cond_ex_q;
endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit; two instances cover both encodings of Cond=1111.
module tb_cond_unit;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    cond_unit_if if0 ();
    cond_unit_if if1 ();

    cond_unit #(.COND_1111_EXEC(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    cond_unit #(.COND_1111_EXEC(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    assign if1.Cond     = if0.Cond;
    assign if1.ALUFlags = if0.ALUFlags;
    assign if1.FlagW    = if0.FlagW;
    assign if1.PCS      = if0.PCS;
    assign if1.NextPC   = if0.NextPC;
    assign if1.RegW     = if0.RegW;
    assign if1.MemW     = if0.MemW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: conditions come in complementary pairs selected by Cond[3:1].
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc, input logic e1111);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        if (cc == 4'b1111) return e1111;
        return cc[0] ? !base : base;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] cc, input logic [1:0] fw, input logic [3:0] alu);
        if0.Cond     = cc;
        if0.FlagW    = fw;
        if0.ALUFlags = alu;
    endtask

    task automatic strobes(input logic pcs, input logic npc, input logic rw, input logic mw);
        if0.PCS    = pcs;
        if0.NextPC = npc;
        if0.RegW   = rw;
        if0.MemW   = mw;
    endtask

    // Load the flag register through an always-executed flag-setting op.
    task automatic load_flags(input logic [3:0] f);
        drive(4'b1110, 2'b11, f);
        step();
        drive(4'b1110, 2'b00, 4'b0000);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'b1110, 2'b00, 4'b0000);
        strobes(1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        nvec++;
        if (if0.Flags !== 4'b0000 || if0.CondExDelayed !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: Flags=%b CDE=%b, want 0000 0", if0.Flags, if0.CondExDelayed);
        end
        nvec++;
        if ({if0.PCWrite, if0.RegWrite, if0.MemWrite} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_strobes: PRM=%b, want 000", {if0.PCWrite, if0.RegWrite, if0.MemWrite});
        end
        if0.NextPC = 1'b1;
        #1;
        nvec++;
        if (if0.PCWrite !== 1'b1) begin
            nerr++;
            $display("FAIL reset_nextpc: PCWrite=%b, want 1", if0.PCWrite);
        end
        @(negedge clk);
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_flag_write_al();
        load_flags(4'b0110);
        nvec++;
        if (if0.Flags !== 4'b0110) begin
            nerr++;
            $display("FAIL al_write: Flags=%b, want 0110", if0.Flags);
        end
        drive(4'b0000, 2'b00, 4'b0000);
        step();
        nvec++;
        if (if0.CondExDelayed !== 1'b1) begin
            nerr++;
            $display("FAIL al_eq_cond: CDE=%b, want 1", if0.CondExDelayed);
        end
        if0.RegW = 1'b1;
        #1;
        nvec++;
        if (if0.RegWrite !== 1'b1) begin
            nerr++;
            $display("FAIL al_regwrite: RegWrite=%b, want 1", if0.RegWrite);
        end
        @(negedge clk);
        if0.RegW = 1'b0;
    endtask

    task automatic test_partial_update();
        load_flags(4'b0110);
        drive(4'b1110, 2'b10, 4'b1001);
        step();
        nvec++;
        if (if0.Flags !== 4'b1010) begin
            nerr++;
            $display("FAIL partial_nz: Flags=%b, want 1010", if0.Flags);
        end
        drive(4'b1110, 2'b01, 4'b0101);
        step();
        nvec++;
        if (if0.Flags !== 4'b1001) begin
            nerr++;
            $display("FAIL partial_cv: Flags=%b, want 1001", if0.Flags);
        end
    endtask

    task automatic test_annul();
        load_flags(4'b0100);
        drive(4'b0001, 2'b11, 4'b1111);
        step();
        nvec++;
        if (if0.Flags !== 4'b0100 || if0.CondExDelayed !== 1'b0) begin
            nerr++;
            $display("FAIL annul_flags: Flags=%b CDE=%b, want 0100 0", if0.Flags, if0.CondExDelayed);
        end
        drive(4'b0001, 2'b00, 4'b0000);
        strobes(1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        nvec++;
        if ({if0.PCWrite, if0.RegWrite, if0.MemWrite} !== 3'b000) begin
            nerr++;
            $display("FAIL annul_strobes: PRM=%b, want 000", {if0.PCWrite, if0.RegWrite, if0.MemWrite});
        end
        if0.NextPC = 1'b1;
        #1;
        nvec++;
        if (if0.PCWrite !== 1'b1) begin
            nerr++;
            $display("FAIL annul_nextpc: PCWrite=%b, want 1", if0.PCWrite);
        end
        @(negedge clk);
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle_hazard();
        load_flags(4'b0000);
        drive(4'b0000, 2'b11, 4'b0100);
        step();
        nvec++;
        if (if0.Flags !== 4'b0000 || if0.CondExDelayed !== 1'b0) begin
            nerr++;
            $display("FAIL hazard: Flags=%b CDE=%b, want 0000 0", if0.Flags, if0.CondExDelayed);
        end
    endtask

    task automatic test_back_to_back();
        // Flags written in one cycle are seen by the condition of the next.
        load_flags(4'b0100);
        drive(4'b0000, 2'b11, 4'b1001);
        step();
        nvec++;
        if (if0.Flags !== 4'b1001 || if0.CondExDelayed !== 1'b1) begin
            nerr++;
            $display("FAIL b2b: Flags=%b CDE=%b, want 1001 1", if0.Flags, if0.CondExDelayed);
        end
        if0.MemW = 1'b1;
        if0.PCS  = 1'b1;
        #1;
        nvec++;
        if ({if0.PCWrite, if0.MemWrite} !== 2'b11) begin
            nerr++;
            $display("FAIL b2b_strobes: PM=%b, want 11", {if0.PCWrite, if0.MemWrite});
        end
        @(negedge clk);
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_instr();
        load_flags(4'b0110);
        step();
        if0.RegW = 1'b1;
        #1;
        nvec++;
        if (if0.RegWrite !== 1'b1) begin
            nerr++;
            $display("FAIL mid_pre: RegWrite=%b, want 1", if0.RegWrite);
        end
        #1 reset = 1'b0;
        #1;
        nvec++;
        if (if0.RegWrite !== 1'b0 || if0.Flags !== 4'b0000 || if0.CondExDelayed !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset: RegWrite=%b Flags=%b CDE=%b, want 0 0000 0",
                     if0.RegWrite, if0.Flags, if0.CondExDelayed);
        end
        @(negedge clk);
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 16; k++) begin
                logic [3:0] fv, kv;
                logic e0, e1;
                fv = 4'(f);
                kv = 4'(k);
                load_flags(fv);
                drive(kv, 2'b00, 4'b0000);
                step();
                e0 = ref_cond(fv, kv, 1'b0);
                e1 = ref_cond(fv, kv, 1'b1);
                nvec++;
                if (if0.CondExDelayed !== e0 || if0.Flags !== fv) begin
                    nerr++;
                    $display("FAIL sweep0 f=%b c=%b: CDE=%b Flags=%b, want %b %b",
                             fv, kv, if0.CondExDelayed, if0.Flags, e0, fv);
                end
                nvec++;
                if (if1.CondExDelayed !== e1 || if1.Flags !== fv) begin
                    nerr++;
                    $display("FAIL sweep1 f=%b c=%b: CDE=%b Flags=%b, want %b %b",
                             fv, kv, if1.CondExDelayed, if1.Flags, e1, fv);
                end
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b0;
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'b1110, 2'b00, 4'b0000);
        test_reset();
        test_flag_write_al();
        test_partial_update();
        test_annul();
        test_same_cycle_hazard();
        test_back_to_back();
        test_reset_mid_instr();
        test_cond_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the multicycle control decoder.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Qualifies the decoder's raw write requests (PCS, NextPC, RegW, MemW) into the final PCWrite, RegWrite and MemWrite strobes that drive the datapath.
- Registers the condition result for one cycle, so writes in later FSM states use the verdict computed when the instruction was decoded.

Parameters:
- COND_1111_EXEC, default 0: Cond=4'b1111 evaluates as never (0) or always (1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 clears state)
- Cond  in  4  Instr[31:28] condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  in  2  decoder flag-write request; [1]=NZ group, [0]=CV group
- PCS  in  1  decoder: instruction writes PC (branch or Rd==15 with RegW)
- NextPC  in  1  FSM: unconditional PC+4 write (fetch)
- RegW  in  1  FSM register-write request
- MemW  in  1  FSM memory-write request
- PCWrite  out  1  qualified PC write enable
- RegWrite  out  1  qualified register-file write enable
- MemWrite  out  1  qualified memory write enable
- Flags  out  4  registered {N,Z,C,V}
- CondExDelayed  out  1  registered condition result

Behaviour:
- Reset (reset==0, asynchronous):
  - Flags=4'b0000 and CondExDelayed=0 immediately.
  - Outputs then follow the combinational equations below, so PCWrite=NextPC and RegWrite=MemWrite=0.
- CondEx (combinational, from registered Flags only, never from ALUFlags). With N,Z,C,V = Flags[3:0]:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: COND_1111_EXEC
- Flag update on rising clk:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx.
  - A disabled group holds its value; groups update independently.
- CondExDelayed <= CondEx on every rising clk, with no enable.
- Output equations (combinational):
  - PCWrite = (PCS & CondExDelayed) | NextPC
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- Latency:
  - Flag-write gating is zero-cycle (uses the CondEx of the same cycle).
  - Write-strobe gating is one cycle, because the FSM asserts RegW/MemW/PCS no earlier than the cycle after decode.
- Simultaneous flag write and evaluation:
  - CondEx in the flag-writing cycle uses the pre-update Flags.
  - New flags are visible to CondEx from the next cycle.
- Failed condition:
  - Flags do not change, even with the S-bit set (FlagW!=0).
  - Register, memory and PC writes are suppressed.
  - NextPC still advances the PC, so the instruction is annulled and the core does not stall.
- Reset mid-instruction:
  - Pending CondExDelayed is cleared, so any in-flight RegW/MemW/PCS is suppressed.
  - Flags return to 0.
- No X propagation: every output is fully defined whenever the inputs are known.

Test Plan:
- Reset: hold reset=0 with RegW=MemW=PCS=1, NextPC=0 -> Flags=0000, CondExDelayed=0, RegWrite=MemWrite=PCWrite=0. Then set NextPC=1 -> PCWrite=1.
- Flag write AL: Cond=1110, FlagW=11, ALUFlags=0110 for one clk -> Flags=0110. Next cycle Cond=0000 (EQ) -> CondEx=1; one clk later with RegW=1 -> RegWrite=1.
- Partial update: Flags=0110, Cond=1110, FlagW=10, ALUFlags=1001 -> Flags=1010 (CV held at 10).
- Annul: Flags=0100 (Z=1), Cond=0001 (NE), FlagW=11, ALUFlags=1111 -> Flags stays 0100. Next cycle RegW=MemW=PCS=1, NextPC=0 -> all three write strobes 0.
- Condition sweep: for each of the 16 Flags values × 16 Cond values, check CondExDelayed one cycle later against a reference model. Run with COND_1111_EXEC=0 and =1.
- Same-cycle hazard: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=0100 -> CondEx=0, so Flags stays 0000 and is not updated to 0100.
